sdi_tx_framer: RTL and testbench

- HD-SDI transmit framer: the transmit-side counterpart of the SDI receive path, producing the 20-bit parallel word stream consumed by the transmit SERDES.
- Generates progressive raster timing and inserts EAV/SAV, line number (LN0/LN1) and per-channel CRC (CRC0/CRC1) words.
- Pulls active-video samples from an upstream source and clamps them out of the TRS code range.
- Output format matches what the SDI receiver decodes: Y channel on [19:10], C channel on [9:0].

---
 rtl/sdi_tx_framer.sv | 158 +++++++++++++++
 tb/tb_sdi_tx_framer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sdi_tx_framer.sv
// HD-SDI transmit framer: raster timing, EAV/SAV, LN and per-channel CRC insertion. Outputs registered (1 cycle after h/line).
// vid_rd is combinational with no backpressure; upstream must supply a sample on every vid_rd cycle.
module sdi_tx_framer #(
   parameter int H_ACTIVE    = 1920,
   parameter int H_TOTAL     = 2200,
   parameter int V_TOTAL     = 1125,
   parameter int V_ACT_FIRST = 42,
   parameter int V_ACT_LAST  = 1121
) (
   input  logic        tx_clk,
   input  logic        rstn,
   input  logic        tx_en,
   input  logic [9:0]  vid_y,
   input  logic [9:0]  vid_c,
   output logic        vid_rd,
   output logic [19:0] txdata,
   output logic        trs_out,
   output logic        sof,
   output logic        vblank,
   output logic        hblank,
   output logic [10:0] ln_out
);
   localparam int B  = H_TOTAL - H_ACTIVE;
   localparam int HW = $clog2(H_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_EAV3 = HW'(3);
   localparam logic [HW-1:0] H_LN0  = HW'(4);
   localparam logic [HW-1:0] H_LN1  = HW'(5);
   localparam logic [HW-1:0] H_CRC0 = HW'(6);
   localparam logic [HW-1:0] H_CRC1 = HW'(7);
   localparam logic [HW-1:0] H_SAV  = HW'(B - 4);
   localparam logic [HW-1:0] H_SAV3 = HW'(B - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(B);
   localparam logic [10:0]   L_FIRST = 11'(V_ACT_FIRST);
   localparam logic [10:0]   L_LAST  = 11'(V_ACT_LAST);
   localparam logic [10:0]   L_TOTAL = 11'(V_TOTAL);
   // x^18+x^5+x^4+1 in LSB-first (bit-reversed) register form
   localparam logic [17:0]   CRC_TAPS = 18'h23000;

   function automatic logic [9:0] f_xyz(input logic v, input logic h);
      return {1'b1, 1'b0, v, h, v ^ h, h, v, v ^ h, 2'b00};
   endfunction

   function automatic logic [9:0] f_clamp(input logic [9:0] d);
      if (d < 10'h004)      return 10'h004;
      else if (d > 10'h3FB) return 10'h3FB;
      else                  return d;
   endfunction

   function automatic logic [17:0] f_crc(input logic [17:0] c, input logic [9:0] d);
      logic [17:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 10; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[17:1]} ^ (fb ? CRC_TAPS : 18'h0);
      end
      return r;
   endfunction

   logic [HW-1:0] r_h;
   logic [10:0]   r_line;
   logic [17:0]   r_crc_y, r_crc_c;

   logic          w_vb, w_act, w_trs;
   logic [9:0]    w_y, w_c, w_ln0, w_ln1;
   logic [17:0]   w_crc_y_nxt, w_crc_c_nxt;

   always_comb begin
      w_vb  = (r_line < L_FIRST) || (r_line > L_LAST);
      w_act = (r_h >= H_ACT);
      w_ln0 = {~r_line[6], r_line[6:0], 2'b00};
      w_ln1 = {1'b1, 3'b000, r_line[10:7], 2'b00};
      w_y   = 10'h040;
      w_c   = 10'h200;
      w_trs = 1'b0;

      if (r_h < H_LN0) begin
         w_trs = 1'b1;
         if (r_h == '0)          begin w_y = 10'h3FF; w_c = 10'h3FF; end
         else if (r_h == H_EAV3) begin w_y = f_xyz(w_vb, 1'b1); w_c = w_y; end
         else                    begin w_y = 10'h000; w_c = 10'h000; end
      end else if (r_h == H_LN0) begin
         w_y = w_ln0; w_c = w_ln0;
      end else if (r_h == H_LN1) begin
         w_y = w_ln1; w_c = w_ln1;
      end else if (r_h == H_CRC0) begin
         w_y = {~r_crc_y[8], r_crc_y[8:0]};
         w_c = {~r_crc_c[8], r_crc_c[8:0]};
      end else if (r_h == H_CRC1) begin
         w_y = {~r_crc_y[17], r_crc_y[17:9]};
         w_c = {~r_crc_c[17], r_crc_c[17:9]};
      end else if (r_h >= H_SAV && !w_act) begin
         w_trs = 1'b1;
         if (r_h == H_SAV)       begin w_y = 10'h3FF; w_c = 10'h3FF; end
         else if (r_h == H_SAV3) begin w_y = f_xyz(w_vb, 1'b0); w_c = w_y; end
         else                    begin w_y = 10'h000; w_c = 10'h000; end
      end else if (w_act && !w_vb) begin
         w_y = f_clamp(vid_y);
         w_c = f_clamp(vid_c);
      end

      // CRC covers the active region (blanking too on vblank lines), then LN0/LN1
      w_crc_y_nxt = r_crc_y;
      w_crc_c_nxt = r_crc_c;
      if (r_h == H_CRC1) begin
         w_crc_y_nxt = '0;
         w_crc_c_nxt = '0;
      end else if (w_act || r_h == H_LN0 || r_h == H_LN1) begin
         w_crc_y_nxt = f_crc(r_crc_y, w_y);
         w_crc_c_nxt = f_crc(r_crc_c, w_c);
      end

      vid_rd = rstn & tx_en & w_act & ~w_vb;
   end

   always_ff @(posedge tx_clk or negedge rstn) begin
      if (!rstn) begin
         r_h     <= '0;
         r_line  <= 11'd1;
         r_crc_y <= '0;
         r_crc_c <= '0;
         txdata  <= '0;
         trs_out <= 1'b0;
         sof     <= 1'b0;
         vblank  <= 1'b0;
         hblank  <= 1'b0;
         ln_out  <= '0;
      end else if (!tx_en) begin
         r_h     <= '0;
         r_line  <= 11'd1;
         r_crc_y <= '0;
         r_crc_c <= '0;
         txdata  <= {10'h040, 10'h200};
         trs_out <= 1'b0;
         sof     <= 1'b0;
         vblank  <= 1'b0;
         hblank  <= 1'b0;
         ln_out  <= '0;
      end else begin
         txdata  <= {w_y, w_c};
         trs_out <= w_trs;
         sof     <= (r_h == '0) && (r_line == 11'd1);
         vblank  <= w_vb;
         hblank  <= ~w_act;
         ln_out  <= r_line;
         r_crc_y <= w_crc_y_nxt;
         r_crc_c <= w_crc_c_nxt;
         if (r_h == H_LAST) begin
            r_h    <= '0;
            r_line <= (r_line == L_TOTAL) ? 11'd1 : r_line + 11'd1;
         end else begin
            r_h <= r_h + HW'(1);
         end
      end
   end
endmodule

// File: tb/tb_sdi_tx_framer.sv
// Bench for sdi_tx_framer on a small raster: random video against a cycle-indexed reference model.
module tb_sdi_tx_framer;
   localparam int HA = 8, HT = 20, VT = 6, VF = 3, VL = 5, B = HT - HA;

   logic        tx_clk = 1'b0;
   logic        rstn, tx_en;
   logic [9:0]  vid_y, vid_c;
   logic        vid_rd;
   logic [19:0] txdata;
   logic        trs_out, sof, vblank, hblank;
   logic [10:0] ln_out;

   int          n_chk = 0, n_bad = 0, mt = 0;
   logic [9:0]  qy[$], qc[$];
   logic [9:0]  crc_cap [2];

   always #5 tx_clk = ~tx_clk;

   sdi_tx_framer #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_TOTAL(VT),
                   .V_ACT_FIRST(VF), .V_ACT_LAST(VL)) dut (
      .tx_clk(tx_clk), .rstn(rstn), .tx_en(tx_en), .vid_y(vid_y), .vid_c(vid_c),
      .vid_rd(vid_rd), .txdata(txdata), .trs_out(trs_out), .sof(sof),
      .vblank(vblank), .hblank(hblank), .ln_out(ln_out));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] xyz(input int v, input int h);
      return 10'(512 + v * 128 + h * 64 + (v ^ h) * 32 + h * 16 + v * 8 + (v ^ h) * 4);
   endfunction

   function automatic logic [9:0] clamp(input int x);
      return 10'((x < 4) ? 4 : (x > 1019) ? 1019 : x);
   endfunction

   // Non-reflected long division over the transmitted bit stream, then bit-reversed
   function automatic logic [17:0] crc_of(input bit sel);
      logic [17:0] r, o;
      logic [9:0]  w;
      logic        fb;
      int          n;
      r = '0;
      n = sel ? qc.size() : qy.size();
      for (int i = 0; i < n; i++) begin
         w = sel ? qc[i] : qy[i];
         for (int b = 0; b < 10; b++) begin
            fb = w[b] ^ r[17];
            r  = {r[16:0], 1'b0} ^ (fb ? 18'h00031 : 18'h0);
         end
      end
      for (int k = 0; k < 18; k++) o[k] = r[17-k];
      return o;
   endfunction

   function automatic logic [9:0] crc_word(input logic [17:0] c, input bit hi);
      int v;
      v = hi ? int'(c >> 9) : int'(c % 512);
      return 10'((v % 512) + (((v >> 8) & 1) ? 0 : 512));
   endfunction

   function automatic logic [9:0] pick();
      case ($urandom_range(0, 5))
         0:       return 10'($urandom_range(0, 3));
         1:       return 10'($urandom_range(1020, 1023));
         2:       return 10'h155;
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic step(input bit en);
      int          h, ln, frame, k;
      bit          vb;
      logic [9:0]  vy, vc, ey, ec;
      logic        e_trs, e_sof, e_vb, e_hb, e_rd;
      logic [10:0] e_ln;
      logic [17:0] cy, cc;
      h     = mt % HT;
      ln    = (mt / HT) % VT + 1;
      frame = mt / (HT * VT);
      vb    = (ln < VF) || (ln > VL);
      vy    = pick();
      vc    = pick();
      if (en && ln == 3 && frame == 0) begin vy = 10'h000; vc = 10'h000; end
      if (en && ln == 3 && frame == 1) begin vy = (h == B) ? 10'h008 : 10'h000; vc = 10'h000; end
      tx_en = en; vid_y = vy; vid_c = vc;
      #1;
      e_rd = en && (h >= B) && !vb;
      check("vid_rd", 32'(vid_rd), 32'(e_rd));

      ey = 10'h040; ec = 10'h200; e_trs = 1'b0; e_sof = 1'b0;
      e_vb = 1'b0; e_hb = 1'b0; e_ln = '0;
      if (en) begin
         e_sof = (h == 0 && ln == 1);
         e_vb  = vb;
         e_hb  = (h < B);
         e_ln  = 11'(ln);
         cy    = crc_of(1'b0);
         cc    = crc_of(1'b1);
         if (h < 4 || (h >= B - 4 && h < B)) begin
            e_trs = 1'b1;
            k  = (h < 4) ? h : h - (B - 4);
            ey = (k == 0) ? 10'h3FF : (k == 3) ? xyz(int'(vb), int'(h < 4)) : 10'h000;
            ec = ey;
         end else if (h == 4) begin
            ey = 10'(((ln & 64) ? 0 : 512) + (ln & 127) * 4); ec = ey;
         end else if (h == 5) begin
            ey = 10'(512 + ((ln >> 7) & 15) * 4); ec = ey;
         end else if (h == 6 || h == 7) begin
            ey = crc_word(cy, h == 7); ec = crc_word(cc, h == 7);
         end else if (h >= B && !vb) begin
            ey = clamp(int'(vy)); ec = clamp(int'(vc));
         end
         if (h >= B || h == 4 || h == 5) begin qy.push_back(ey); qc.push_back(ec); end
         if (h == 7) begin qy.delete(); qc.delete(); end
      end

      @(posedge tx_clk);
      #1;
      check("txdata",  32'(txdata),  32'({ey, ec}));
      check("trs_out", 32'(trs_out), 32'(e_trs));
      check("sof",     32'(sof),     32'(e_sof));
      check("vblank",  32'(vblank),  32'(e_vb));
      check("hblank",  32'(hblank),  32'(e_hb));
      check("ln_out",  32'(ln_out),  32'(e_ln));
      if (en && h == 6 && ln == 4 && frame < 2) crc_cap[frame] = txdata[19:10];
      if (en) mt++;
      else begin mt = 0; qy.delete(); qc.delete(); end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_txdata"},  32'(txdata),  32'h0);
      check({tag, "_trs"},     32'(trs_out), 32'h0);
      check({tag, "_sof"},     32'(sof),     32'h0);
      check({tag, "_vblank"},  32'(vblank),  32'h0);
      check({tag, "_hblank"},  32'(hblank),  32'h0);
      check({tag, "_ln"},      32'(ln_out),  32'h0);
      check({tag, "_vid_rd"},  32'(vid_rd),  32'h0);
   endtask

   initial begin
      crc_cap[0] = '0;
      crc_cap[1] = '0;
      rstn  = 1'b0;
      tx_en = 1'b1;
      vid_y = 10'h155;
      vid_c = 10'h000;
      #23;
      check_zero("rst");

      tx_en = 1'b0;
      @(negedge tx_clk);
      rstn = 1'b1;
      step(1'b0);
      step(1'b0);

      // two full frames, stopping inside the active region of line 3
      for (int i = 0; i < 2 * HT * VT + 2 * HT + 14; i++) step(1'b1);
      check("crc_bitflip", 32'(crc_cap[0] != crc_cap[1]), 32'h1);

      for (int i = 0; i < 4; i++) step(1'b0);
      for (int i = 0; i < HT * VT + 10; i++) step(1'b1);

      #3;
      rstn = 1'b0;
      #1;
      check_zero("async_rst");
      mt = 0;
      qy.delete();
      qc.delete();
      #10;
      rstn = 1'b1;
      for (int i = 0; i < 3 * HT + 5; i++) step(1'b1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
